shift_issue_stage: RTL and testbench

- Operand/issue stage of the 16-bit datapath shift path.
- Registers a decoded shift operation and drives the combinational shifter (`in`, `RLamount`, `lui`).
- Captures the shifter's `out` into a small output buffer, with valid/ready handshakes on both sides.
- Feeds the writeback path with result plus destination register tag.

---
 rtl/shift_issue_stage_if.sv | 28 ++
 rtl/shift_issue_stage.sv | 98 +++++++++
 tb/tb_shift_issue_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/shift_issue_stage_if.sv
// shift_issue_stage_if: operand, shifter and writeback handshake bundle of the shift issue stage
interface shift_issue_stage_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_dir;
  logic [3:0]       in_amt;
  logic             in_lui;
  logic [7:0]       in_imm;
  logic [2:0]       in_rd;
  logic [15:0]      sh_in;
  logic [4:0]       sh_rlamount;
  logic             sh_lui;
  logic [15:0]      sh_out;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [2:0]       out_rd;
  logic [CNT_W-1:0] ops_done;
  modport slave (
    input  in_valid, in_data, in_dir, in_amt, in_lui, in_imm, in_rd, sh_out, out_ready,
    output in_ready, sh_in, sh_rlamount, sh_lui, out_valid, out_data, out_rd, ops_done
  );
  modport master (
    output in_valid, in_data, in_dir, in_amt, in_lui, in_imm, in_rd, sh_out, out_ready,
    input  in_ready, sh_in, sh_rlamount, sh_lui, out_valid, out_data, out_rd, ops_done
  );
endinterface

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: operand register feeding an external shifter, result FIFO with registered head
module shift_issue_stage #(
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  shift_issue_stage_if.slave io
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(OUT_DEPTH);
  logic             s1_valid_q, s1_valid_d;
  logic [15:0]      sh_in_q, sh_in_d;
  logic [4:0]       sh_rlamount_q, sh_rlamount_d;
  logic             sh_lui_q, sh_lui_d;
  logic [2:0]       s1_rd_q, s1_rd_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic [2:0]       out_rd_q, out_rd_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  logic [15:0]      data_mem [OUT_DEPTH];
  logic [2:0]       rd_mem [OUT_DEPTH];
  logic             push, pop, load, bypass;
  // handshake: a full buffer still takes S1 when the head leaves in the same cycle
  always_comb begin
    pop  = out_valid_q & io.out_ready;
    push = s1_valid_q & ((count_q != FULL) | pop);
    load = io.in_valid & (!s1_valid_q | push);
  end
  // S1 operand register; LUI ignores data/dir/amt and presents the immediate in the low byte
  always_comb begin
    s1_valid_d    = load | (s1_valid_q & !push);
    sh_in_d       = load ? (io.in_lui ? {8'h00, io.in_imm} : io.in_data) : sh_in_q;
    sh_rlamount_d = load ? (io.in_lui ? 5'd0 : {io.in_dir, io.in_amt}) : sh_rlamount_q;
    sh_lui_d      = load ? io.in_lui : sh_lui_q;
    s1_rd_d       = load ? io.in_rd : s1_rd_q;
  end
  // buffer bookkeeping; the head register is refilled from the slot that becomes head,
  // taking the shifter result directly when that slot is the one being written now
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    out_valid_d = count_d != '0;
    bypass      = push & (wr_ptr_q == rd_ptr_d);
    out_data_d  = !out_valid_d ? out_data_q : bypass ? io.sh_out : data_mem[rd_ptr_d];
    out_rd_d    = !out_valid_d ? out_rd_q : bypass ? s1_rd_q : rd_mem[rd_ptr_d];
    ops_done_d  = ops_done_q + CNT_W'(pop);
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      sh_in_q       <= '0;
      sh_rlamount_q <= '0;
      sh_lui_q      <= 1'b0;
      s1_rd_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_rd_q      <= '0;
      ops_done_q    <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      sh_in_q       <= sh_in_d;
      sh_rlamount_q <= sh_rlamount_d;
      sh_lui_q      <= sh_lui_d;
      s1_rd_q       <= s1_rd_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_rd_q      <= out_rd_d;
      ops_done_q    <= ops_done_d;
    end
  end
  // result storage; contents are only meaningful between write and read pointer
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= io.sh_out;
      rd_mem[wr_ptr_q]   <= s1_rd_q;
    end
  end
  assign io.in_ready    = !s1_valid_q | push;
  assign io.sh_in       = sh_in_q;
  assign io.sh_rlamount = sh_rlamount_q;
  assign io.sh_lui      = sh_lui_q;
  assign io.out_valid   = out_valid_q;
  assign io.out_data    = out_data_q;
  assign io.out_rd      = out_rd_q;
  assign io.ops_done    = ops_done_q;
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed checks of the shift issue stage with a behavioural shifter
module tb_shift_issue_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int n_seen = 0;
  int stray = 0;
  logic [15:0] t4_data [4] = '{16'h0F00, 16'h2340, 16'h00AB, 16'h0001};
  logic [15:0] t2_data [3] = '{16'h0002, 16'h2000, 16'h8000};
  logic [3:0]  t2_amt  [3] = '{4'd1, 4'd13, 4'd15};
  shift_issue_stage_if #(.CNT_W(16)) bus();
  shift_issue_stage #(.OUT_DEPTH(2), .CNT_W(16)) dut (.clk(clk), .reset(reset), .io(bus));
  always #5 clk = ~clk;
  assign bus.sh_out = bus.sh_lui ? {bus.sh_in[7:0], 8'h00} :
                      bus.sh_rlamount[4] ? bus.sh_in << bus.sh_rlamount[3:0] :
                      bus.sh_in >> bus.sh_rlamount[3:0];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] d, input logic dir, input logic [3:0] amt,
                       input logic lui, input logic [7:0] imm, input logic [2:0] rd);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_dir   = dir;
    bus.in_amt   = amt;
    bus.in_lui   = lui;
    bus.in_imm   = imm;
    bus.in_rd    = rd;
    #1;
  endtask
  task automatic observe;
    if (bus.out_valid && bus.out_ready) begin
      check("t5_rd", 32'(bus.out_rd), 32'(n_seen));
      check("t5_data", 32'(bus.out_data), 32'(1) << n_seen);
      n_seen++;
    end
  endtask
  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_data"}, 32'(bus.out_data), 0);
    check({tag, "_out_rd"}, 32'(bus.out_rd), 0);
    check({tag, "_sh_in"}, 32'(bus.sh_in), 0);
    check({tag, "_sh_rl"}, 32'(bus.sh_rlamount), 0);
    check({tag, "_sh_lui"}, 32'(bus.sh_lui), 0);
    check({tag, "_ops_done"}, 32'(bus.ops_done), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    check_cleared("rst");
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    // single right shift
    bus.out_ready = 1'b1;
    drive(1, 16'h8001, 0, 4'd3, 0, 8'h00, 3'd5);
    check("t1_in_ready", 32'(bus.in_ready), 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t1_sh_in", 32'(bus.sh_in), 32'h8001);
    check("t1_sh_rl", 32'(bus.sh_rlamount), 32'h03);
    check("t1_early", 32'(bus.out_valid), 0);
    tick;
    check("t1_out_valid", 32'(bus.out_valid), 1);
    check("t1_out_data", 32'(bus.out_data), 32'h1000);
    check("t1_out_rd", 32'(bus.out_rd), 5);
    tick;
    check("t1_ops_done", 32'(bus.ops_done), 1);
    check("t1_empty", 32'(bus.out_valid), 0);
    // back-to-back left shifts
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        drive(1, 16'h8001, 1, t2_amt[i], 0, 8'h00, 3'(i + 1));
        check("t2_in_ready", 32'(bus.in_ready), 1);
      end else drive(0, 0, 0, 0, 0, 0, 0);
      if (i >= 2) begin
        check("t2_out_valid", 32'(bus.out_valid), 1);
        check("t2_out_data", 32'(bus.out_data), 32'(t2_data[i - 2]));
        check("t2_out_rd", 32'(bus.out_rd), 32'(i - 1));
      end
      tick;
    end
    check("t2_ops_done", 32'(bus.ops_done), 4);
    check("t2_empty", 32'(bus.out_valid), 0);
    // load upper immediate
    drive(1, 16'hFFFF, 1, 4'd7, 1, 8'hA5, 3'd6);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t3_sh_in", 32'(bus.sh_in), 32'h00A5);
    check("t3_sh_lui", 32'(bus.sh_lui), 1);
    check("t3_sh_rl", 32'(bus.sh_rlamount), 0);
    tick;
    check("t3_out_data", 32'(bus.out_data), 32'hA500);
    check("t3_out_rd", 32'(bus.out_rd), 6);
    tick;
    check("t3_ops_done", 32'(bus.ops_done), 5);
    // backpressure: two buffered plus S1, fourth op stalls
    bus.out_ready = 1'b0;
    drive(1, 16'hF000, 0, 4'd4, 0, 8'h00, 3'd0);
    tick;
    drive(1, 16'h1234, 1, 4'd4, 0, 8'h00, 3'd1);
    tick;
    drive(1, 16'hABCD, 0, 4'd8, 0, 8'h00, 3'd2);
    tick;
    drive(1, 16'h0001, 1, 4'd0, 0, 8'h00, 3'd3);
    check("t4_stall", 32'(bus.in_ready), 0);
    check("t4_head", 32'(bus.out_data), 32'(t4_data[0]));
    tick;
    check("t4_stall2", 32'(bus.in_ready), 0);
    check("t4_sh_in", 32'(bus.sh_in), 32'hABCD);
    check("t4_sh_rl", 32'(bus.sh_rlamount), 32'h08);
    check("t4_head2", 32'(bus.out_data), 32'(t4_data[0]));
    bus.out_ready = 1'b1;
    #1;
    check("t4_release", 32'(bus.in_ready), 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      check("t4_out_valid", 32'(bus.out_valid), 1);
      check("t4_out_data", 32'(bus.out_data), 32'(t4_data[i]));
      check("t4_out_rd", 32'(bus.out_rd), 32'(i));
      tick;
    end
    check("t4_empty", 32'(bus.out_valid), 0);
    check("t4_ops_done", 32'(bus.ops_done), 9);
    // push and pop together while full, pointers wrap
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h0001, 1, 4'(i), 0, 8'h00, 3'(i));
      tick;
    end
    drive(1, 16'h0001, 1, 4'd3, 0, 8'h00, 3'd3);
    check("t5_full", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    #1;
    check("t5_pushpop", 32'(bus.in_ready), 1);
    observe;
    tick;
    drive(1, 16'h0001, 1, 4'd4, 0, 8'h00, 3'd4);
    check("t5_pushpop2", 32'(bus.in_ready), 1);
    observe;
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && n_seen < 5; k++) begin
      observe;
      tick;
    end
    check("t5_count", 32'(n_seen), 5);
    check("t5_ops_done", 32'(bus.ops_done), 14);
    // reset with buffered entries, S1 busy, and an accept plus pop pending
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h00FF, 1, 4'd4, 0, 8'h00, 3'(i + 1));
      tick;
    end
    drive(1, 16'h1111, 1, 4'd1, 0, 8'h00, 3'd7);
    bus.out_ready = 1'b1;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cleared("t6");
    check("t6_in_ready", 32'(bus.in_ready), 1);
    for (int k = 0; k < 4; k++) begin
      if (bus.out_valid) stray++;
      tick;
    end
    check("t6_stray", 32'(stray), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
